// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge engine for raster-order greyscale frames.
// Two line buffers hold the previous two rows; a 3x2 window register plus the
// column being accepted form the 3x3 neighbourhood. Each accepted pixel k
// completes the window centred on output k-(IMG_W+1), which is registered one
// cycle later. After the last pixel of a frame the block flushes the remaining
// IMG_W+1 outputs, which all lie on the frame border and are therefore 0.
module sobel_stream #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             out_valid,
  output logic [PIX_W-1:0] edge_out,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);
  localparam int GW = PIX_W + 4;

  localparam logic [CW-1:0]    COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0]    COL_TWO    = CW'(2);
  localparam logic [RW-1:0]    ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [RW-1:0]    ROW_ONE    = RW'(1);
  localparam logic [RW-1:0]    ROW_TWO    = RW'(2);
  localparam logic [FW-1:0]    FLUSH_LAST = FW'(IMG_W);
  localparam logic [PIX_W-1:0] MAXV       = '1;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_e;
  typedef enum logic [1:0] {
    M_SIGNED = 2'd0,
    M_MAG    = 2'd1,
    M_MAX    = 2'd2,
    M_THRESH = 2'd3
  } mode_e;
  typedef logic signed [GW-1:0] grad_t;

  // Zero-extend a pixel into the signed gradient width.
  function automatic grad_t ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // Clamp a signed gradient-domain value to [0, MAXV].
  function automatic logic [PIX_W-1:0] clamp(input grad_t v);
    if (v[GW-1]) return '0;
    if (v > ext(MAXV)) return MAXV;
    return v[PIX_W-1:0];
  endfunction

  // Control / output registers
  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic [PIX_W-1:0]  edge_q;
  logic [FW-1:0]     flush_cnt_q;

  // Datapath registers
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  mode_e             mode_q;
  logic [PIX_W-1:0]  thresh_q;
  logic [PIX_W-1:0]  lb_top_q [IMG_W];  // row r-2, indexed by column
  logic [PIX_W-1:0]  lb_mid_q [IMG_W];  // row r-1, indexed by column
  logic [PIX_W-1:0]  win_q    [3][2];   // [row top/mid/bot][col C-2, C-1]

  logic              accept;
  logic [PIX_W-1:0]  col_top;
  logic [PIX_W-1:0]  col_mid;
  logic              interior;
  grad_t             gx, gy, ax, ay, mag_sum, sgn_sum, max_g;
  logic [PIX_W-1:0]  mag_c;
  logic [PIX_W-1:0]  edge_d;

  assign accept   = in_valid && in_ready_q;
  assign col_top  = lb_top_q[col_q];
  assign col_mid  = lb_mid_q[col_q];
  // Centre is (row_q-1, col_q-1); interior when both lie in [1, size-2].
  assign interior = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  // Gradients over the window: stored columns C-2, C-1 plus incoming column C.
  assign gx = (ext(col_top) + (ext(col_mid) <<< 1) + ext(pix_data))
            - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
  assign gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(pix_data))
            - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(col_top));
  assign ax      = gx[GW-1] ? -gx : gx;
  assign ay      = gy[GW-1] ? -gy : gy;
  assign mag_sum = (ax + ay) >>> 1;
  assign sgn_sum = (-gx - gy) >>> 1;
  assign max_g   = (ax > ay) ? ax : ay;

  // Select the edge value for the current window according to the frame mode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    edge_d = '0;
    mag_c  = clamp(mag_sum);
    if (interior) begin
      unique case (mode_q)
        M_SIGNED: edge_d = clamp(sgn_sum);
        M_MAG:    edge_d = mag_c;
        M_MAX:    edge_d = clamp(max_g);
        M_THRESH: edge_d = (mag_c >= thresh_q) ? MAXV : '0;
      endcase
    end
  end

  // Raster counters, line buffers, window shift and per-frame mode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= M_SIGNED;
      thresh_q <= '0;
      // NOTE: the line buffers are flop arrays, so they are cleared here with
      // the rest of the state; a RAM-backed buffer would not be reset.
      for (int i = 0; i < IMG_W; i++) begin
        lb_top_q[i] <= '0;
        lb_mid_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (accept) begin
      lb_top_q[col_q] <= col_mid;
      lb_mid_q[col_q] <= pix_data;
      win_q[0][0]     <= win_q[0][1];
      win_q[0][1]     <= col_top;
      win_q[1][0]     <= win_q[1][1];
      win_q[1][1]     <= col_mid;
      win_q[2][0]     <= win_q[2][1];
      win_q[2][1]     <= pix_data;
      if (row_q == '0 && col_q == '0) begin
        mode_q   <= mode_e'(mode);
        thresh_q <= thresh;
      end
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Frame FSM with registered handshake, output and status signals.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_FILL;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      edge_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      edge_q      <= '0;
      unique case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          // Pixel IMG_W sits at row 1, column 0; after it the window is primed.
          if (accept && row_q == ROW_ONE && col_q == '0) state_q <= S_RUN;
        end
        S_RUN: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            edge_q      <= edge_d;
            if (row_q == ROW_LAST && col_q == COL_LAST) begin
              state_q     <= S_FLUSH;
              in_ready_q  <= 1'b0;
              flush_cnt_q <= '0;
            end
          end
        end
        S_FLUSH: begin
          // Remaining outputs are the last border positions: always 0.
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          if (flush_cnt_q == FLUSH_LAST) begin
            out_last_q <= 1'b1;
            state_q    <= S_FILL;
          end else begin
            flush_cnt_q <= flush_cnt_q + FW'(1);
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign edge_out  = edge_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on 8x8 frames: the driver pushes the
// expected edge map of each frame from a 2-D reference model, and a monitor
// pops and compares on every out_valid pulse.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] pix_data = '0;
  logic [1:0] mode = '0;
  logic [7:0] thresh = '0;
  logic       out_valid;
  logic [7:0] edge_out;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pix_data (pix_data),
    .mode     (mode),
    .thresh   (thresh),
    .out_valid(out_valid),
    .edge_out (edge_out),
    .out_last (out_last),
    .busy     (busy)
  );

  typedef struct {
    int v;
    bit last;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   img[H][W];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   pulse_cnt = 0;
  int   first_out_cyc = -1;
  int   first_acc_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_edge(input int r, input int c, input int md, input int th);
    int gx, gy, mag;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    mag = sat((iabs(gx) + iabs(gy)) >>> 1);
    case (md)
      0:       return sat((-gx - gy) >>> 1);
      1:       return mag;
      2:       return sat((iabs(gx) > iabs(gy)) ? iabs(gx) : iabs(gy));
      default: return (mag >= th) ? 255 : 0;
    endcase
  endfunction

  // Outputs that n_pix accepted pixels produce (all of them for a full frame).
  task automatic push_expected(input int md, input int th, input int n_pix);
    int   n_out;
    exp_t e;
    n_out = (n_pix >= W*H) ? W*H : n_pix - W - 1;
    for (int j = 0; j < n_out; j++) begin
      e.v    = ref_edge(j / W, j % W, md, th);
      e.last = (j == W*H-1);
      e.idx  = j;
      sb.push_back(e);
    end
  endtask

  task automatic fill_img(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c < 4) ? 50 : 0;
          2:       img[r][c] = (c < 4) ? 0 : 200;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  // ---------------- driver ----------------
  task automatic send_pixel(input int p, input int gap, output int acc_cyc);
    int waited;
    while (gap > 0 && int'($urandom_range(99)) < gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    pix_data = p[7:0];
    waited   = 0;
    acc_cyc  = -1;
    while (acc_cyc < 0) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc_cyc = cyc;
      @(posedge clk); #1;
      waited++;
      if (acc_cyc < 0 && waited > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout: in_ready low for %0d cycles, required high", waited);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  // Send n_pix pixels of img; md2 >= 0 changes the mode pins after pixel 30.
  // A partial frame ends with a one-cycle reset right after the last acceptance.
  task automatic drive_frame(input int md, input int th, input int gap,
                             input int md2, input int th2, input int n_pix);
    int a;
    push_expected(md, th, n_pix);
    mode   = md[1:0];
    thresh = th[7:0];
    for (int k = 0; k < n_pix; k++) begin
      send_pixel(img[k / W][k % W], gap, a);
      if (k == 0) first_acc_cyc = a;
      if (md2 >= 0 && k == 30) begin
        mode   = md2[1:0];
        thresh = th2[7:0];
      end
    end
    if (n_pix < W*H) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_cnt++;
      check("ready_low_in_flush", {31'b0, in_ready}, 32'd0);
    end
    if (out_valid === 1'b1) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: edge_out=%0d appeared, required no output", edge_out);
      end else begin
        e = sb.pop_front();
        check($sformatf("edge[%0d]", e.idx), {24'b0, edge_out}, e.v);
        check($sformatf("last[%0d]", e.idx), {31'b0, out_last}, {31'b0, e.last});
        if (e.idx == 0) first_out_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int th2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_edge_out",  {24'b0, edge_out},  32'd0);
    check("rst_out_last",  {31'b0, out_last},  32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_at_release", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Flat frame: all-zero edge map, latency and flush length.
    fill_img(0);
    busy_cnt = 0;
    drive_frame(1, 0, 0, -1, 0, W*H);
    wait_drain();
    check("first_out_latency", first_out_cyc - first_acc_cyc, 32'd10);
    check("busy_cycles", busy_cnt, 32'd9);

    // 50/0 vertical step in MAG, MAX and SIGNED.
    fill_img(1);
    drive_frame(1, 0, 0, -1, 0, W*H); wait_drain();
    drive_frame(2, 0, 0, -1, 0, W*H); wait_drain();
    drive_frame(0, 0, 0, -1, 0, W*H); wait_drain();

    // 0/200 step: saturation in MAG, negative clamp in SIGNED.
    fill_img(2);
    drive_frame(1, 0, 0, -1, 0, W*H); wait_drain();
    drive_frame(0, 0, 0, -1, 0, W*H); wait_drain();

    // Threshold exactly at and just above the step magnitude.
    fill_img(1);
    drive_frame(3, 100, 0, -1, 0, W*H); wait_drain();
    drive_frame(3, 101, 0, -1, 0, W*H); wait_drain();

    // Two back-to-back random frames with input gaps; mode pins change mid-frame 1.
    pulse_cnt = 0;
    th2 = int'($urandom_range(255));
    fill_img(3);
    drive_frame(1, 0, 50, 2, th2, W*H);
    fill_img(3);
    drive_frame(2, th2, 50, -1, 0, W*H);
    wait_drain();
    check("pulses_two_frames", pulse_cnt, 32'd128);

    // Reset after 30 accepted pixels, then a fresh frame.
    fill_img(3);
    drive_frame(0, 0, 20, -1, 0, 30);
    wait_drain();
    fill_img(3);
    drive_frame(3, int'($urandom_range(40, 200)), 30, -1, 0, W*H);
    wait_drain();
    fill_img(3);
    drive_frame(0, 0, 0, -1, 0, W*H);
    wait_drain();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
